// File: rtl/tron_pkg.sv
// Shared definitions for the light-cycle mover: direction codes, FSM state
// type and direction-qualification helpers.
package tron_pkg;

  localparam logic [4:0] DIR_UP    = 5'b10000;
  localparam logic [4:0] DIR_DOWN  = 5'b01000;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_RIGHT = 5'b00010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CRASHED = 2'd2
  } state_t;

  // True when b points exactly opposite to a.
  function automatic logic is_reverse(input logic [4:0] a, input logic [4:0] b);
    return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP))    ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

  function automatic logic is_valid_dir(input logic [4:0] d);
    logic ok;
    case (d)
      DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tron_cycle_mover_if.sv
// Control/status bundle between the game controller (master) and the mover (slave).
interface tron_cycle_mover_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           start;
  logic [4:0]     dir_in;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [4:0]     heading;
  logic           step_valid;
  logic           crashed;
  logic           running;

  modport master (
    output start, dir_in,
    input  x_out, y_out, heading, step_valid, crashed, running
  );

  modport slave (
    input  start, dir_in,
    output x_out, y_out, heading, step_valid, crashed, running
  );
endinterface

// File: rtl/tron_cycle_mover_divider.sv
// Move-period divider: counts 0..STEP_DIV-1 while enabled and flags the last count.
module tron_step_divider #(
  parameter int STEP_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic wrap
);
  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_r;

  assign wrap = enable && !clear && (count_r == LAST);

  // Period counter with priority clear over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      if (count_r == LAST) count_r <= '0;
      else                 count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end
endmodule

// File: rtl/tron_cycle_mover.sv
// Light-cycle head mover: turn latch, reversal rejection, per-period stepping, walls.
// Build option TRON_WRAP_EN makes walls wrap around instead of crashing.
module tron_cycle_mover
  import tron_pkg::*;
#(
  parameter int         X_W       = 8,
  parameter int         Y_W       = 7,
  parameter int         X_MAX     = 159,
  parameter int         Y_MAX     = 119,
  parameter int         START_X   = 40,
  parameter int         START_Y   = 60,
  parameter logic [4:0] START_DIR = 5'b00010,
  parameter int         STEP_DIV  = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  tron_cycle_mover_if.slave bus
);
  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);
  localparam logic [X_W-1:0] X_INIT = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_INIT = Y_W'(START_Y);

  state_t         state_r, state_next_s;
  logic [X_W-1:0] x_r, x_next_s;
  logic [Y_W-1:0] y_r, y_next_s;
  logic [4:0]     heading_r, pending_r, pending_next_s;
  logic           step_valid_r, hit_wall_s, wrap_s, restart_s, running_s, crashed_s;

  assign restart_s = bus.start && (state_r != RUN);

  tron_step_divider #(.STEP_DIV(STEP_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart_s),
    .enable (state_r == RUN),
    .wrap   (wrap_s)
  );

  // Turn latch input: a turn arriving on the wrap cycle applies to that same move.
  always_comb begin
    pending_next_s = pending_r;
    if ((state_r == RUN) && is_valid_dir(bus.dir_in) &&
        !is_reverse(heading_r, bus.dir_in) && (bus.dir_in != heading_r)) begin
      pending_next_s = bus.dir_in;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Candidate head position for the upcoming move, plus wall detection.
  always_comb begin
    x_next_s   = x_r;
    y_next_s   = y_r;
    hit_wall_s = 1'b0;
    case (pending_next_s)
      DIR_UP: begin
        if (y_r == '0) begin
`ifdef TRON_WRAP_EN
          y_next_s = Y_LAST;
`else
          hit_wall_s = 1'b1;
`endif
        end else begin
          y_next_s = y_r - Y_ONE;
        end
      end
      DIR_DOWN: begin
        if (y_r == Y_LAST) begin
`ifdef TRON_WRAP_EN
          y_next_s = '0;
`else
          hit_wall_s = 1'b1;
`endif
        end else begin
          y_next_s = y_r + Y_ONE;
        end
      end
      DIR_LEFT: begin
        if (x_r == '0) begin
`ifdef TRON_WRAP_EN
          x_next_s = X_LAST;
`else
          hit_wall_s = 1'b1;
`endif
        end else begin
          x_next_s = x_r - X_ONE;
        end
      end
      DIR_RIGHT: begin
        if (x_r == X_LAST) begin
`ifdef TRON_WRAP_EN
          x_next_s = '0;
`else
          hit_wall_s = 1'b1;
`endif
        end else begin
          x_next_s = x_r + X_ONE;
        end
      end
      default: begin
        x_next_s   = x_r;
        y_next_s   = y_r;
        hit_wall_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (bus.start) state_next_s = RUN; else state_next_s = IDLE;
      RUN:     if (wrap_s && hit_wall_s) state_next_s = CRASHED; else state_next_s = RUN;
      CRASHED: if (bus.start) state_next_s = RUN; else state_next_s = CRASHED;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode from the registered state.
  always_comb begin
    running_s = 1'b0;
    crashed_s = 1'b0;
    case (state_r)
      RUN:     running_s = 1'b1;
`ifdef TRON_WRAP_EN
      CRASHED: crashed_s = 1'b0;
`else
      CRASHED: crashed_s = 1'b1;
`endif
      default: begin
        running_s = 1'b0;
        crashed_s = 1'b0;
      end
    endcase
  end

  // Head position, heading, turn latch and step pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r          <= X_INIT;
      y_r          <= Y_INIT;
      heading_r    <= START_DIR;
      pending_r    <= START_DIR;
      step_valid_r <= 1'b0;
    end else begin
      step_valid_r <= 1'b0;
      if (restart_s) begin
        x_r       <= X_INIT;
        y_r       <= Y_INIT;
        heading_r <= START_DIR;
        pending_r <= START_DIR;
      end else if (state_r == RUN) begin
        pending_r <= pending_next_s;
        if (wrap_s) begin
          heading_r <= pending_next_s;
          if (!hit_wall_s) begin
            x_r          <= x_next_s;
            y_r          <= y_next_s;
            step_valid_r <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.x_out      = x_r;
  assign bus.y_out      = y_r;
  assign bus.heading    = heading_r;
  assign bus.step_valid = step_valid_r;
  assign bus.running    = running_s;
  assign bus.crashed    = crashed_s;
endmodule

// File: doc/tron_cycle_mover.md
Name: tron_cycle_mover

Overview:
- Consumes the 5-bit one-hot direction bus produced by the player input decoder and turns it into light-cycle motion on the playfield grid.
- Latches turn requests, rejects 180-degree reversals and steps the cycle head one cell per move period.
- Flags wall crashes; outputs feed the trail writer and the VGA framebuffer write port.

Parameters:
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- X_MAX, 159, last valid column.
- Y_MAX, 119, last valid row.
- START_X, 40, column after reset or restart.
- START_Y, 60, row after reset or restart.
- START_DIR, 5'b00010, heading after reset or restart (RIGHT).
- STEP_DIV, 1_000_000, clk cycles per move; legal range 2 or more.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse: IDLE/CRASHED -> RUN, reloads start position.
- dir_in  in  5  one-hot direction: bit4 UP, bit3 DOWN, bit2 LEFT, bit1 RIGHT, bit0 unused.
- x_out  out  X_W  current head column.
- y_out  out  Y_W  current head row.
- heading  out  5  current applied direction, same one-hot encoding.
- step_valid  out  1  one-cycle pulse, same cycle x_out/y_out take a new value.
- crashed  out  1  sticky, high in CRASHED.
- running  out  1  high in RUN.

Behaviour:
- Reset values: x_out=START_X, y_out=START_Y, heading=START_DIR, pending=START_DIR, step_valid=0, crashed=0, running=0, divider=0, state=IDLE.
- States:
  - IDLE: no motion, divider held at 0; start -> RUN.
  - RUN: motion enabled.
  - CRASHED: outputs frozen; start -> RUN.
- start in IDLE or CRASHED, on the same edge: reload position and heading to START_*, clear divider, clear crashed. start in RUN is ignored.
- Turn latch (pending), sampled every clk in RUN:
  - accept dir_in only when it is exactly one of the four values 10000/01000/00100/00010;
  - reject when dir_in is the reverse of the current heading (UP<->DOWN, LEFT<->RIGHT);
  - reject when dir_in equals the current heading (no change);
  - otherwise pending <= dir_in. A later accepted value overwrites an earlier one: last-wins within a period.
- Divider: counts 0..STEP_DIV-1 in RUN, wraps to 0. On wrap, in the same edge, heading <= pending and the head moves one cell in the pending direction.
- Coordinates: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
- Wall rule, without the optional feature:
  - a move that would leave 0..X_MAX or 0..Y_MAX is not applied;
  - position holds, step_valid stays 0, crashed<=1, running<=0, state -> CRASHED;
  - the edge cases are x=0 moving LEFT, x=X_MAX moving RIGHT, y=0 moving UP, y=Y_MAX moving DOWN.
- step_valid: exactly one pulse per successful move; its latency is one clk after the divider-wrap edge condition (registered output).
- Simultaneous events: if an accepted dir_in arrives on the wrap cycle, it is taken into pending and used for that same move.
- Reset mid-RUN: immediate return to reset values; any pending turn is lost.
- dir_in is never evaluated in IDLE or CRASHED; pending holds its value there.

Optional Feature:
- Macro: TRON_WRAP_EN.
- Defined:
  - walls wrap instead of crashing: x=X_MAX moving RIGHT -> 0, x=0 moving LEFT -> X_MAX, same for y with Y_MAX;
  - step_valid pulses normally on a wrapping move;
  - the CRASHED state is unreachable; crashed is tied 0.
- Not defined: the wall crash rule above applies.

Decomposition:
- Package tron_pkg holds:
  - DIR_UP=5'b10000, DIR_DOWN=5'b01000, DIR_LEFT=5'b00100, DIR_RIGHT=5'b00010;
  - state typedef {IDLE, RUN, CRASHED};
  - function is_reverse(a,b);
  - function is_valid_dir(d).
- One sub-module is natural: tron_step_divider (counter with clear and enable, outputs a wrap pulse). Everything else stays in tron_cycle_mover.

Test Plan (STEP_DIV=4, defaults otherwise):
- Reset then start, dir_in=00010 held: x_out steps 40,41,42 at 4-clk intervals; y_out=60; one step_valid pulse per step.
- Heading RIGHT, dir_in=00100 (reverse) for 10 clks: heading stays 00010 and x keeps incrementing. Then dir_in=10000: the next move gives y=59 with x unchanged.
- Within one period drive 10000 then 01000: the DOWN request is rejected as the reverse of the UP request? No — both are checked against the applied heading RIGHT, so both are accepted and last-wins gives y=61 on the next move.
- X_MAX=43, heading RIGHT from x=40, no TRON_WRAP_EN: x reaches 43. The next wrap raises crashed=1 and running=0 with x holding 43 and no step_valid. start then reloads (40,60) with crashed=0.
- Same setup with TRON_WRAP_EN: x goes 43 -> 0 with step_valid, and crashed stays 0.
- reset asserted mid-RUN between divider wraps: all outputs return to reset values within the same cycle (async). After deassert, no motion occurs until start.
